fp32_mul_rr_scheduler: RTL
==========================

// Module: fp32_mul_rr_scheduler
// PURPOSE
//  Round-robin scheduler sharing one pipelined FP32 multiply datapath (operand unpack, mantissa
//  multiply/normalise/GRS round, pack) among NREQ requesters. Accepts operand pairs by
//  valid/ready, issues at most one op per cycle, tracks in-flight ops by tag, and returns
//  each result to its owner's one-entry response buffer. Sits between client FSMs and the
//  FP_32/MUL datapath; contains no arithmetic itself.
// PARAMETERS
//  NREQ  4  number of requesters (2..8)
//  LAT   3  datapath latency in cycles, mul_valid -> mul_res_valid (1..8)
//  TAGW  $clog2(NREQ)  tag width (derived, not overridable)
// PORTS
//  clk            in   1          clock, all state on rising edge
//  rst            in   1          synchronous reset, active-high
//  req_valid      in   NREQ       requester i has operands
//  req_ready      out  NREQ       one-hot grant; handshake when req_valid[i]&req_ready[i]
//  req_a          in   32*NREQ    operand A, IEEE-754 single, slice [32i+31:32i]
//  req_b          in   32*NREQ    operand B, same packing
//  mul_valid      out  1          issue strobe to datapath (registered)
//  mul_a, mul_b   out  32 each    issued operands (registered)
//  mul_tag        out  TAGW       owner index of issued op (registered)
//  mul_res_valid  in   1          datapath result strobe
//  mul_res        in   32         datapath result
//  mul_res_tag    in   TAGW       tag returned with result
//  rsp_valid      out  NREQ       response buffer i full
//  rsp_data       out  32*NREQ    response for requester i
//  rsp_ready      in   NREQ       requester i consumes response
// BEHAVIOUR
//  - Reset: req_ready=0, mul_valid=0, mul_a/mul_b/mul_tag=0, rsp_valid=0, rsp_data=0,
//    busy[]=0, rr_ptr=NREQ-1 (requester 0 wins first). rst mid-operation drops all
//    in-flight ops and buffered responses; mul_res_valid is ignored in the reset cycle.
//  - busy[i] set on accept of requester i; cleared on rsp_valid[i]&rsp_ready[i].
//    Max one outstanding op per requester, so response buffer can never overflow.
//  - eligible[i] = req_valid[i] & ~busy[i]. Grant (combinational req_ready, cycle t):
//    first eligible index scanning rr_ptr+1, rr_ptr+2, ... mod NREQ. At most one bit set.
//    rr_ptr <= granted index on handshake; unchanged if no grant.
//  - req_ready may only depend on req_valid and registered state (no ready->valid loop).
//  - Issue: accepted at t -> mul_valid=1 with operands and tag at t+1. No accept at t ->
//    mul_valid=0 at t+1. Datapath has no backpressure; one issue per cycle sustained.
//  - Return: mul_res_valid at t+1+LAT writes rsp_data[tag], sets rsp_valid[tag] at t+2+LAT.
//    Total latency accept->rsp_valid = LAT+2 cycles.
//  - Result strobe for a tag whose buffer is already full or not busy: sticky internal
//    error flag (assertion target), data discarded.
//  - Same-cycle rsp handshake on i and new req_valid[i]: i is not eligible that cycle
//    (busy evaluated on registered value); eligible next cycle.
//  - rsp_valid[i] holds with stable rsp_data until rsp_ready[i].
// CONFIGURATION
//  FP32_MUL_SCHED_PRIO0_EN defined: requester 0 is fixed highest priority; if eligible it
//    is granted regardless of rr_ptr, and rr_ptr is NOT updated by its grants; others
//    round-robin among themselves.
//  Undefined: pure round-robin over all NREQ as above.
// TESTING
//  1 single op: req 0 a=0x3FC00000 b=0x40000000 (1.5*2.0), bench model returns after LAT=3
//    -> req_ready[0] at t, mul_valid at t+1, rsp_valid[0]=1 rsp_data=0x40400000 at t+5.
//  2 all 4 requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per
//    cycle once busy clears; no requester starved; mul_tag matches grant order.
//  3 req 2 holds rsp_ready=0 -> after its one op, req_ready[2] stays 0; others keep
//    issuing; rsp_data[2] stable; on rsp_ready[2]=1 req 2 eligible next cycle.
//  4 rst asserted one cycle with 3 ops in flight -> all outputs reset values next cycle;
//    late mul_res_valid strobes ignored; req 0 granted first after reset.
//  5 FP32_MUL_SCHED_PRIO0_EN defined, req 0 and 1 always valid -> req 0 granted every
//    time it is not busy; req 1 granted only in cycles req 0 is busy.
//  6 bench injects mul_res_valid with tag of idle requester -> error flag set, rsp_valid
//    unchanged.

Source files
------------

// File: rtl/fp32_mul_rr_scheduler.sv
// -----------------------------------------------------------------------------
// fp32_mul_rr_scheduler
//   Round-robin scheduler that shares one pipelined FP32 multiply datapath among
//   NREQ requesters. It accepts operand pairs by valid/ready and issues at most
//   one op per cycle to the datapath. Each requester owns a one-entry response
//   buffer, and the buffer is addressed by the tag that returns with each result.
//   The block contains no arithmetic.
//
//   Optional build macro: FP32_MUL_SCHED_PRIO0_EN
//     defined   : requester 0 has fixed top priority. Its grants do not move
//                 rr_ptr, and the other requesters round-robin among themselves.
//     undefined : pure round-robin over all NREQ requesters.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   req_valid/ready   per-requester handshake (req_ready is a one-hot grant)
//   req_a/req_b       32-bit operands, slice [32i+31:32i] belongs to requester i
//   mul_valid/a/b/tag registered issue to the datapath
//   mul_res_*         result strobe, data and tag from the datapath
//   rsp_valid/data    per-requester response buffer
//   rsp_ready         per-requester response consume
// -----------------------------------------------------------------------------
module fp32_mul_rr_scheduler #(
  parameter  int NREQ = 4,
  parameter  int LAT  = 3,
  localparam int TAGW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic                 mul_valid,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  output logic [TAGW-1:0]      mul_tag,
  input  logic                 mul_res_valid,
  input  logic [31:0]          mul_res,
  input  logic [TAGW-1:0]      mul_res_tag,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [32*NREQ-1:0]   rsp_data,
  input  logic [NREQ-1:0]      rsp_ready
);

`ifdef FP32_MUL_SCHED_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  // LAT belongs to the datapath. It only appears in this legality check.
  if (NREQ < 2 || NREQ > 8 || LAT < 1 || LAT > 8) begin : g_bad_param
    $error("fp32_mul_rr_scheduler: NREQ must be 2..8 and LAT 1..8");
  end

  logic [NREQ-1:0][31:0] a_vec, b_vec, rsp_mem;
  logic [NREQ-1:0]       busy;
  logic [NREQ-1:0]       eligible;
  logic [TAGW-1:0]       rr_ptr;
  logic [TAGW-1:0]       grant_idx;
  logic                  accept;
  logic                  res_ok;
  logic                  err_flag;

  assign a_vec    = req_a;
  assign b_vec    = req_b;
  assign rsp_data = rsp_mem;

  // busy is registered, so a response consumed this cycle frees its requester
  // next cycle. rst gating keeps req_ready low while reset is applied.
  assign eligible = req_valid & ~busy & {NREQ{~rst}};

  // Grant: scan rr_ptr+1, rr_ptr+2, ... modulo NREQ. With PRIO0, an eligible
  // requester 0 wins before the scan, and the scan then never selects index 0.
  // NOTE: every combinational output gets a default first, so no path can hold
  // an old value (no latch).
  always_comb begin
    req_ready = '0;
    grant_idx = '0;
    accept    = 1'b0;
    if (PRIO0 && eligible[0]) begin
      req_ready[0] = 1'b1;
      accept       = 1'b1;
    end
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!accept && eligible[idx] && !(PRIO0 && idx == 0)) begin
        req_ready[idx] = 1'b1;
        grant_idx      = TAGW'(idx);
        accept         = 1'b1;
      end
    end
  end

  // A result is legal only for an in-range tag that is outstanding and whose
  // buffer is empty. Anything else is dropped and recorded in err_flag.
  assign res_ok = (int'(mul_res_tag) < NREQ) && busy[mul_res_tag] &&
                  !rsp_valid[mul_res_tag];

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_valid <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_tag   <= '0;
      busy      <= '0;
      rsp_valid <= '0;
      // NOTE: the response buffers are cleared on reset because rsp_data is
      // visible at the ports. Storage that nobody observes would not need it.
      rsp_mem   <= '0;
      rr_ptr    <= TAGW'(NREQ - 1);
      err_flag  <= 1'b0;
    end else begin
      mul_valid <= accept;
      if (accept) begin
        mul_a           <= a_vec[grant_idx];
        mul_b           <= b_vec[grant_idx];
        mul_tag         <= grant_idx;
        busy[grant_idx] <= 1'b1;
        if (!(PRIO0 && grant_idx == '0)) rr_ptr <= grant_idx;
      end
      // Accept needs ~busy and release needs rsp_valid, which implies busy.
      // The set and the clear of busy therefore never hit the same bit.
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
          busy[i]      <= 1'b0;
        end
      end
      if (mul_res_valid) begin
        if (res_ok) begin
          rsp_mem[mul_res_tag]   <= mul_res;
          rsp_valid[mul_res_tag] <= 1'b1;
        end else begin
          err_flag <= 1'b1;
        end
      end
    end
  end

  // err_flag is sticky until reset. It lets verification see stray results.
  cover property (@(posedge clk) err_flag);

endmodule
